// File: rtl/enable_ctrl.sv
// Run/idle control for the downstream enable counter: synchronizes and debounces
// the start/stop and clear buttons, and generates the prescaled enable strobe and clear pulse.
module enable_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRESCALE        = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_run,
  input  logic btn_clr,
  output logic enable,
  output logic clear,
  output logic running
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Button index 0 is start/stop, index 1 is clear.
  logic [1:0]    btn;
  logic [1:0]    s1;
  logic [1:0]    s2;
  logic [1:0]    stable;
  logic [1:0]    stable_q;
  logic [CW-1:0] db_cnt [2];
  logic [1:0]    press;
  logic [0:0]    state;
  logic [PW-1:0] prescaler;
  logic          run_press;
  logic          clr_press;

  assign btn = {btn_clr, btn_run};

  // Two-flop synchronizer stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // Debounce stage: stable follows s2 only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      stable_q <= stable;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign press     = stable & ~stable_q;
  assign run_press = press[0];
  assign clr_press = press[1];

  // FSM and prescaler stage; clear takes priority over start/stop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      prescaler <= '0;
      clear     <= 1'b0;
    end else begin
      clear <= clr_press;
      if (clr_press) begin
        state     <= IDLE;
        prescaler <= '0;
      end else if (run_press) begin
        state     <= (state == IDLE) ? RUN : IDLE;
        prescaler <= '0;
      end else if (state == RUN) begin
        prescaler <= (prescaler == PS_LAST) ? '0 : prescaler + 1'b1;
      end else begin
        prescaler <= '0;
      end
    end
  end

  assign running = (state == RUN);
  assign enable  = (state == RUN) && (prescaler == PS_LAST);

endmodule

// File: tb/tb_enable_ctrl.sv
// Randomized and directed bench for enable_ctrl against a cycle-level reference
// model built from raw button sample history.
module tb_enable_ctrl;
  localparam int DB = 4;
  localparam int PS = 3;

  logic clk = 1'b0;
  logic reset;
  logic btn_run;
  logic btn_clr;
  logic enable;
  logic clear;
  logic running;

  enable_ctrl #(.DEBOUNCE_CYCLES(DB), .PRESCALE(PS)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_run (btn_run),
    .btn_clr (btn_clr),
    .enable  (enable),
    .clear   (clear),
    .running (running)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: hr/hc hold raw samples, index 0 = most recent edge.
  bit hr [DB+1];
  bit hc [DB+1];
  bit sr, sqr, sc, sqc;
  bit m_run, m_clr;
  int n, m_start;
  int clr_seen, run_rises;

  function automatic bit m_en();
    return m_run && (((n - m_start) % PS) == PS - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= DB; i++) begin
      hr[i] = 1'b0;
      hc[i] = 1'b0;
    end
    sr = 0; sqr = 0; sc = 0; sqc = 0;
    m_run = 0; m_clr = 0; n = 0; m_start = 0;
  endtask

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic step();
    bit fr, fc, pr, pc, prev_run;
    @(posedge clk);
    prev_run = m_run;
    if (reset) begin
      model_reset();
    end else begin
      fr = 1'b1;
      fc = 1'b1;
      for (int i = 1; i <= DB; i++) begin
        if (hr[i] == sr) fr = 1'b0;
        if (hc[i] == sc) fc = 1'b0;
      end
      pr = sr & ~sqr;
      pc = sc & ~sqc;
      n++;
      m_clr = pc;
      if (pc) begin
        m_run = 1'b0;
      end else if (pr) begin
        m_run = !m_run;
        m_start = n;
      end
      sqr = sr;
      sqc = sc;
      sr  = sr ^ fr;
      sc  = sc ^ fc;
      for (int i = DB; i > 0; i--) begin
        hr[i] = hr[i-1];
        hc[i] = hc[i-1];
      end
      hr[0] = btn_run;
      hc[0] = btn_clr;
    end
    if (m_clr) clr_seen++;
    if (m_run && !prev_run) run_rises++;
    @(negedge clk);
    chk("running", running, m_run);
    chk("enable", enable, m_en());
    chk("clear", clear, m_clr);
  endtask

  task automatic async_reset_check();
    #3 reset = 1'b1;
    #1;
    chk("rst_running", running, 1'b0);
    chk("rst_enable", enable, 1'b0);
    chk("rst_clear", clear, 1'b0);
    step();
    reset = 1'b0;
  endtask

  int seg_len;
  bit lvl_r, lvl_c, bouncy;
  bit bseq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    model_reset();
    reset = 1'b1;
    btn_run = 1'b0;
    btn_clr = 1'b0;
    clr_seen = 0;
    run_rises = 0;
    step();
    step();
    chk("reset_running", running, 1'b0);
    chk("reset_enable", enable, 1'b0);
    chk("reset_clear", clear, 1'b0);
    reset = 1'b0;
    repeat (3) step();

    // Held start button: running after 7th edge counted from the sampling edge.
    btn_run = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("run_latency", running, (i >= 7));
    end
    for (int i = 8; i <= 13; i++) begin
      step();
      chk("first_enable", enable, (i == 9) || (i == 12));
    end
    repeat (10) step();
    chk("held_still_running", running, 1'b1);

    // Clean stop press, then restart.
    btn_run = 1'b0;
    repeat (10) step();
    btn_run = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      chk("stop_latency", running, (i < 7));
    end
    btn_run = 1'b0;
    repeat (10) step();
    btn_run = 1'b1;
    repeat (15) step();
    btn_run = 1'b0;
    repeat (8) step();

    // Clear while running, held: exactly one pulse.
    chk("pre_clear_running", running, 1'b1);
    clr_seen = 0;
    btn_clr = 1'b1;
    repeat (25) step();
    chk("held_clr_one_pulse", (clr_seen == 1), 1'b1);
    chk("clr_stops_run", running, 1'b0);
    btn_clr = 1'b0;
    repeat (10) step();

    // Bounce then hold from IDLE: exactly one transition.
    run_rises = 0;
    for (int i = 0; i < 5; i++) begin
      btn_run = bseq[i];
      step();
    end
    btn_run = 1'b1;
    repeat (15) step();
    chk("bounce_one_event", (run_rises == 1), 1'b1);
    btn_run = 1'b0;
    repeat (10) step();
    btn_run = 1'b1;
    repeat (10) step();
    btn_run = 1'b0;
    repeat (10) step();

    // Both pressed together from IDLE: clear wins.
    chk("both_pre_idle", running, 1'b0);
    clr_seen = 0;
    run_rises = 0;
    btn_run = 1'b1;
    btn_clr = 1'b1;
    repeat (15) step();
    chk("both_one_clear", (clr_seen == 1), 1'b1);
    chk("both_no_run", (run_rises == 0), 1'b1);
    btn_run = 1'b0;
    btn_clr = 1'b0;
    repeat (10) step();

    // Asynchronous reset mid-RUN.
    btn_run = 1'b1;
    repeat (12) step();
    btn_run = 1'b0;
    repeat (4) step();
    chk("pre_async_running", running, 1'b1);
    async_reset_check();
    run_rises = 0;
    repeat (20) step();
    chk("post_reset_idle", (run_rises == 0), 1'b1);

    // Randomized button activity with occasional asynchronous resets.
    for (int s = 0; s < 400; s++) begin
      seg_len = $urandom_range(1, 12);
      lvl_r   = 1'($urandom_range(0, 1));
      lvl_c   = ($urandom_range(0, 5) == 0);
      bouncy  = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < seg_len; c++) begin
        btn_run = bouncy ? 1'($urandom_range(0, 1)) : lvl_r;
        btn_clr = lvl_c;
        step();
      end
      if ($urandom_range(0, 59) == 0) async_reset_check();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
